// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
`timescale 1ns / 1ps

package cmp_pkg;

  localparam int CMP_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cmp_state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_result_t;

  localparam cmp_result_t CMP_RESULT_NONE = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};

  // Turn the two sticky running flags into a one-hot verdict.
  // With neither flag set the operands matched on every bit.
  function automatic cmp_result_t cmp_resolve(input logic gt, input logic lt);
    cmp_result_t res;
    res.eq = ~gt & ~lt;
    res.gt = gt;
    res.lt = lt;
    return res;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit compare cell: classifies one bit pair as equal, greater or less.
`timescale 1ns / 1ps

module cmp_bit_cell (
  input  logic x,
  input  logic y,
  output logic eq_b,
  output logic gt_b,
  output logic lt_b
);

  assign eq_b = ~(x ^ y);
  assign gt_b = x & ~y;
  assign lt_b = ~x & y;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator. Operands are latched on an
// accepted start, then walked MSB-first one bit pair per clock through a
// single compare cell. The first differing pair decides the verdict; the
// verdict is registered and announced with a one-cycle done pulse.
`timescale 1ns / 1ps

module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = CMP_DEFAULT_WIDTH,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam bit EARLY = (EARLY_EXIT != 0);

  cmp_state_e       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gt;
  logic             r_lt;
  logic             r_busy;
  logic             r_done;
  cmp_result_t      r_res;

  logic             w_eq_b;
  logic             w_gt_b;
  logic             w_lt_b;
  logic             w_undecided;
  logic             w_gt_next;
  logic             w_lt_next;
  logic             w_last;

  // The one compare cell always looks at the current shift-register MSBs.
  cmp_bit_cell u_cell (
    .x    (r_sa[WIDTH-1]),
    .y    (r_sb[WIDTH-1]),
    .eq_b (w_eq_b),
    .gt_b (w_gt_b),
    .lt_b (w_lt_b)
  );

  // Next running flags and the finish decision for the pair under compare.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, starting
    // with these defaults, so no latch can be inferred.
    w_undecided = 1'b0;
    w_gt_next   = 1'b0;
    w_lt_next   = 1'b0;
    w_last      = 1'b0;

    w_undecided = ~r_gt & ~r_lt;
    // Flags are sticky: only the first differing pair may set one.
    w_gt_next   = r_gt | (w_undecided & w_gt_b);
    w_lt_next   = r_lt | (w_undecided & w_lt_b);
    w_last      = (r_cnt == '0) || (EARLY && !w_eq_b);
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, whatever the statement order.
    if (!rst_n) begin
      // NOTE: the operand shift registers are plain flops, not a memory,
      // so clearing them on reset is cheap and keeps state deterministic.
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= CMP_RESULT_NONE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_gt  <= w_gt_next;
          r_lt  <= w_lt_next;
          r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
          r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_res   <= cmp_resolve(w_gt_next, w_lt_next);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign eq   = r_res.eq;
  assign gt   = r_res.gt;
  assign lt   = r_res.lt;

endmodule
